// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the shared-memory-port arbiter, its two requesters
// (instruction fetch, MEM stage) and the single memory port.
// Ports: if_* fetch side, dm_* MEM-stage side, mem_* memory side.
// slave modport = arbiter view; master modport = requesters + memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  // Instruction-fetch requester
  logic                  if_read;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [31:0]           if_readdata;
  logic                  if_busywait;

  // MEM-stage requester
  logic [3:0]            dm_read;       // [3] enable, [2:0] funct3
  logic [2:0]            dm_write;      // [2] enable, [1:0] size
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [31:0]           dm_writedata;
  logic [31:0]           dm_readdata;
  logic                  dm_busywait;
  logic                  dm_misaligned;

  // Shared memory port
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_writedata;
  logic [3:0]            mem_byte_en;
  logic [31:0]           mem_readdata;
  logic                  mem_busywait;

  modport slave (
    input  if_read, if_addr,
    output if_readdata, if_busywait,
    input  dm_read, dm_write, dm_addr, dm_writedata,
    output dm_readdata, dm_busywait, dm_misaligned,
    output mem_read, mem_write, mem_addr, mem_writedata, mem_byte_en,
    input  mem_readdata, mem_busywait
  );

  modport master (
    output if_read, if_addr,
    input  if_readdata, if_busywait,
    output dm_read, dm_write, dm_addr, dm_writedata,
    input  dm_readdata, dm_busywait, dm_misaligned,
    input  mem_read, mem_write, mem_addr, mem_writedata, mem_byte_en,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between fetch and MEM stage, DM fixed priority;
//   formats stores (replication + byte enables) and extends loads.
// Latency: grant edge -> strobe next cycle; DONE one cycle after the first edge
//   with MEM_BUSYWAIT low; misaligned DM goes straight to DONE without a strobe.
// Backpressure: per-requester busywait (combinational) holds the pipeline until
//   that requester's DONE cycle; MEM_BUSYWAIT stretches the access cycle.
// Ports: clk_i, rst_ni (synchronous, active low), bus (slave modport).
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_ACC,
    S_DM_ACC,
    S_IF_DONE,
    S_DM_DONE
  } state_e;

  state_e                state_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [3:0]            mem_be_q;
  logic [31:0]           if_rdata_q;
  logic [31:0]           dm_rdata_q;
  logic                  dm_mis_q;
  // Op context latched at the DM grant edge, used when the read data returns
  logic                  dm_is_wr_q;
  logic [2:0]            ld_funct3_q;
  logic [1:0]            ld_off_q;

  // ---------------------------------------------------------------------------
  // DM request decode (evaluated in IDLE, consumed at the grant edge)
  // ---------------------------------------------------------------------------
  logic        dm_req;
  logic        dm_wr_sel;
  logic [1:0]  dm_size;
  logic [1:0]  dm_off;
  logic        dm_mis_d;
  logic [31:0] st_data_d;
  logic [3:0]  st_be_d;

  assign dm_req    = bus.dm_read[3] | bus.dm_write[2];
  // A simultaneous read+write request performs only the write
  assign dm_wr_sel = bus.dm_write[2];
  assign dm_size   = dm_wr_sel ? bus.dm_write[1:0] : bus.dm_read[1:0];
  assign dm_off    = bus.dm_addr[1:0];

  always_comb begin
    dm_mis_d = 1'b0;
    case (dm_size)
      2'b00:   dm_mis_d = 1'b0;
      2'b01:   dm_mis_d = dm_off[0];
      default: dm_mis_d = |dm_off;
    endcase
  end

  always_comb begin
    st_data_d = bus.dm_writedata;
    st_be_d   = 4'b1111;
    case (bus.dm_write[1:0])
      2'b00: begin
        st_data_d = {4{bus.dm_writedata[7:0]}};
        st_be_d   = 4'b0001 << dm_off;
      end
      2'b01: begin
        st_data_d = {2{bus.dm_writedata[15:0]}};
        st_be_d   = dm_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data_d = bus.dm_writedata;
        st_be_d   = 4'b1111;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the returned word, using the latched op context
  // ---------------------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data_d;

  always_comb begin
    ld_byte = bus.mem_readdata[7:0];
    case (ld_off_q)
      2'd0: ld_byte = bus.mem_readdata[7:0];
      2'd1: ld_byte = bus.mem_readdata[15:8];
      2'd2: ld_byte = bus.mem_readdata[23:16];
      2'd3: ld_byte = bus.mem_readdata[31:24];
      default: ld_byte = bus.mem_readdata[7:0];
    endcase
  end

  assign ld_half = ld_off_q[1] ? bus.mem_readdata[31:16] : bus.mem_readdata[15:0];

  always_comb begin
    ld_data_d = bus.mem_readdata;
    case (ld_funct3_q)
      3'b000:  ld_data_d = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data_d = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data_d = {24'd0, ld_byte};
      3'b101:  ld_data_d = {16'd0, ld_half};
      default: ld_data_d = bus.mem_readdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM with registered memory-side and result outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      dm_mis_q    <= 1'b0;
      dm_is_wr_q  <= 1'b0;
      ld_funct3_q <= '0;
      ld_off_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dm_req) begin
            dm_is_wr_q  <= dm_wr_sel;
            ld_funct3_q <= bus.dm_read[2:0];
            ld_off_q    <= dm_off;
            if (dm_mis_d) begin
              // Rejected without touching memory; result is zero with the flag
              dm_mis_q   <= 1'b1;
              dm_rdata_q <= '0;
              state_q    <= S_DM_DONE;
            end else begin
              mem_addr_q <= {bus.dm_addr[ADDR_WIDTH-1:2], 2'b00};
              if (dm_wr_sel) begin
                mem_write_q <= 1'b1;
                mem_wdata_q <= st_data_d;
                mem_be_q    <= st_be_d;
              end else begin
                mem_read_q <= 1'b1;
                mem_be_q   <= 4'b0000;
              end
              state_q <= S_DM_ACC;
            end
          end else if (bus.if_read) begin
            mem_addr_q <= {bus.if_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_read_q <= 1'b1;
            mem_be_q   <= 4'b0000;
            state_q    <= S_IF_ACC;
          end
        end

        S_IF_ACC: begin
          if (!bus.mem_busywait) begin
            mem_read_q <= 1'b0;
            if_rdata_q <= bus.mem_readdata;
            state_q    <= S_IF_DONE;
          end
        end

        S_DM_ACC: begin
          if (!bus.mem_busywait) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            // Stores leave the last load result untouched
            if (!dm_is_wr_q) begin
              dm_rdata_q <= ld_data_d;
            end
            state_q <= S_DM_DONE;
          end
        end

        S_IF_DONE: begin
          state_q <= S_IDLE;
        end

        S_DM_DONE: begin
          dm_mis_q <= 1'b0;
          state_q  <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // DONE drops a requester's stall for exactly one cycle; the DONE->IDLE edge
  // ignores requests, so the completed one is never re-served.
  assign bus.if_busywait = rst_ni & bus.if_read & (state_q != S_IF_DONE);
  assign bus.dm_busywait = rst_ni & dm_req & (state_q != S_DM_DONE);

  assign bus.if_readdata   = if_rdata_q;
  assign bus.dm_readdata   = dm_rdata_q;
  assign bus.dm_misaligned = dm_mis_q;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_writedata = mem_wdata_q;
  assign bus.mem_byte_en   = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, wait-state fetch, DM priority,
// store formatting, load extension, misaligned rejection, reset mid-access.
// Memory model: busywait held for mem_wait cycles after each strobe rise.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  int          mem_wait = 0;
  int          wait_cnt = 0;
  logic [31:0] mem_word = '0;

  mem_port_arbiter_if #(.ADDR_WIDTH(32)) bus();

  mem_port_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Wait-state memory; counter restarts whenever the strobe is low
  always @(posedge clk) begin
    if (!(bus.mem_read || bus.mem_write)) wait_cnt <= 0;
    else if (wait_cnt < mem_wait)         wait_cnt <= wait_cnt + 1;
  end
  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (wait_cnt < mem_wait);
  assign bus.mem_readdata = mem_word;

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs cycles until the requester's stall drops (its DONE cycle), counting
  // stall and strobe cycles on the way; bounded so a stuck DUT still ends.
  task automatic run_until_free(input bit dm, output int bw_n, output int rd_n,
                                output int wr_n, output logic [31:0] addr_seen);
    logic bw;
    bw_n = 0; rd_n = 0; wr_n = 0; addr_seen = '0;
    bw = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bw = dm ? bus.dm_busywait : bus.if_busywait;
      if (!bw) break;
      bw_n++;
      if (bus.mem_read) begin rd_n++; addr_seen = bus.mem_addr; end
      if (bus.mem_write) wr_n++;
      cyc();
    end
    check("done_reached", {31'd0, bw}, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] exp);
    bus.dm_read = {1'b1, f3};
    bus.dm_addr = addr;
    #1;
    check({tag, "_bw0"}, {31'd0, bus.dm_busywait}, 32'd1);
    cyc();
    check({tag, "_rd"}, {31'd0, bus.mem_read}, 32'd1);
    check({tag, "_be"}, {28'd0, bus.mem_byte_en}, 32'd0);
    check({tag, "_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
    cyc();
    check({tag, "_bwdone"}, {31'd0, bus.dm_busywait}, 32'd0);
    check({tag, "_data"}, bus.dm_readdata, exp);
    bus.dm_read = '0;
    cyc();
  endtask

  task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] d, input logic [31:0] exp_wd,
                          input logic [3:0] exp_be, input logic [31:0] keep_rd);
    bus.dm_write     = {1'b1, sz};
    bus.dm_addr      = addr;
    bus.dm_writedata = d;
    #1;
    check({tag, "_bw0"}, {31'd0, bus.dm_busywait}, 32'd1);
    cyc();
    check({tag, "_wr"}, {31'd0, bus.mem_write}, 32'd1);
    check({tag, "_rd"}, {31'd0, bus.mem_read}, 32'd0);
    check({tag, "_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
    check({tag, "_wdata"}, bus.mem_writedata, exp_wd);
    check({tag, "_be"}, {28'd0, bus.mem_byte_en}, {28'd0, exp_be});
    cyc();
    check({tag, "_wrdrop"}, {31'd0, bus.mem_write}, 32'd0);
    check({tag, "_bwdone"}, {31'd0, bus.dm_busywait}, 32'd0);
    check({tag, "_rdkeep"}, bus.dm_readdata, keep_rd);
    bus.dm_write = '0;
    cyc();
  endtask

  initial begin
    int bw_n, rd_n, wr_n;
    logic [31:0] a;

    // ---- Reset with a fetch pending ----
    rst_n            = 1'b0;
    bus.if_read      = 1'b1;
    bus.if_addr      = 32'h0000_0104;
    bus.dm_read      = '0;
    bus.dm_write     = '0;
    bus.dm_addr      = '0;
    bus.dm_writedata = '0;
    mem_wait         = 3;
    mem_word         = 32'h0051_0093;
    cyc();
    cyc();
    check("rst_if_bw",   {31'd0, bus.if_busywait}, 32'd0);
    check("rst_dm_bw",   {31'd0, bus.dm_busywait}, 32'd0);
    check("rst_mem_rd",  {31'd0, bus.mem_read}, 32'd0);
    check("rst_mem_wr",  {31'd0, bus.mem_write}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wd",  bus.mem_writedata, 32'd0);
    check("rst_mem_be",  {28'd0, bus.mem_byte_en}, 32'd0);
    check("rst_if_rd",   bus.if_readdata, 32'd0);
    check("rst_dm_rd",   bus.dm_readdata, 32'd0);
    check("rst_mis",     {31'd0, bus.dm_misaligned}, 32'd0);

    // ---- Fetch with 3 wait states, granted right after release ----
    rst_n = 1'b1;
    #1;
    run_until_free(1'b0, bw_n, rd_n, wr_n, a);
    check("f3w_bw_cycles",  bw_n, 32'd5);
    check("f3w_rd_cycles",  rd_n, 32'd4);
    check("f3w_addr",       a, 32'h0000_0104);
    check("f3w_rd_low",     {31'd0, bus.mem_read}, 32'd0);
    check("f3w_data",       bus.if_readdata, 32'h0051_0093);
    bus.if_read = 1'b0;
    cyc();

    // ---- Simultaneous IF + LW: DM first, IF after DONE + one IDLE ----
    mem_wait    = 1;
    mem_word    = 32'h1234_5678;
    bus.if_read = 1'b1;
    bus.if_addr = 32'h0000_0040;
    bus.dm_read = 4'b1010;
    bus.dm_addr = 32'h0000_0200;
    #1;
    check("pri_c0_dmbw", {31'd0, bus.dm_busywait}, 32'd1);
    check("pri_c0_ifbw", {31'd0, bus.if_busywait}, 32'd1);
    cyc();
    check("pri_c1_rd",   {31'd0, bus.mem_read}, 32'd1);
    check("pri_c1_addr", bus.mem_addr, 32'h0000_0200);
    check("pri_c1_ifbw", {31'd0, bus.if_busywait}, 32'd1);
    cyc();
    check("pri_c2_rd",   {31'd0, bus.mem_read}, 32'd1);
    cyc();
    check("pri_c3_rd",   {31'd0, bus.mem_read}, 32'd0);
    check("pri_c3_dmbw", {31'd0, bus.dm_busywait}, 32'd0);
    check("pri_c3_data", bus.dm_readdata, 32'h1234_5678);
    check("pri_c3_mis",  {31'd0, bus.dm_misaligned}, 32'd0);
    check("pri_c3_ifbw", {31'd0, bus.if_busywait}, 32'd1);
    bus.dm_read = '0;
    mem_word    = 32'h0000_0013;
    cyc();
    check("pri_c4_rd",   {31'd0, bus.mem_read}, 32'd0);
    check("pri_c4_ifbw", {31'd0, bus.if_busywait}, 32'd1);
    cyc();
    check("pri_c5_rd",   {31'd0, bus.mem_read}, 32'd1);
    check("pri_c5_addr", bus.mem_addr, 32'h0000_0040);
    check("pri_c5_ifbw", {31'd0, bus.if_busywait}, 32'd1);
    cyc();
    check("pri_c6_ifbw", {31'd0, bus.if_busywait}, 32'd1);
    cyc();
    check("pri_c7_ifbw", {31'd0, bus.if_busywait}, 32'd0);
    check("pri_c7_data", bus.if_readdata, 32'h0000_0013);
    bus.if_read = 1'b0;
    cyc();

    // ---- Stores (zero wait): read result from the LW must survive ----
    mem_wait = 0;
    do_store("sb", 2'b00, 32'h0000_0013, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1000, 32'h1234_5678);
    do_store("sh", 2'b01, 32'h0000_0022, 32'h1234_BEEF, 32'hBEEF_BEEF, 4'b1100, 32'h1234_5678);
    do_store("sw", 2'b10, 32'h0000_0030, 32'hDEAD_0001, 32'hDEAD_0001, 4'b1111, 32'h1234_5678);

    // ---- Loads from word 0x80FF_7F01 ----
    mem_word = 32'h80FF_7F01;
    do_load("lb2",  3'b000, 32'h0000_0002, 32'hFFFF_FFFF);
    do_load("lbu3", 3'b100, 32'h0000_0003, 32'h0000_0080);
    do_load("lh2",  3'b001, 32'h0000_0002, 32'hFFFF_80FF);
    do_load("lhu0", 3'b101, 32'h0000_0000, 32'h0000_7F01);
    do_load("lb0",  3'b000, 32'h0000_0000, 32'h0000_0001);

    // ---- Misaligned LW: no strobe, one stall cycle ----
    bus.dm_read = 4'b1010;
    bus.dm_addr = 32'h0000_0102;
    #1;
    check("mis_c0_bw",   {31'd0, bus.dm_busywait}, 32'd1);
    cyc();
    check("mis_c1_bw",   {31'd0, bus.dm_busywait}, 32'd0);
    check("mis_c1_flag", {31'd0, bus.dm_misaligned}, 32'd1);
    check("mis_c1_data", bus.dm_readdata, 32'd0);
    check("mis_c1_rd",   {31'd0, bus.mem_read}, 32'd0);
    check("mis_c1_wr",   {31'd0, bus.mem_write}, 32'd0);
    bus.dm_read = '0;
    cyc();
    check("mis_c2_flag", {31'd0, bus.dm_misaligned}, 32'd0);
    check("mis_c2_rd",   {31'd0, bus.mem_read}, 32'd0);

    // ---- Reset in cycle 2 of a 5-wait fetch ----
    mem_wait    = 5;
    mem_word    = 32'h0BAD_0BAD;
    bus.if_read = 1'b1;
    bus.if_addr = 32'h0000_0080;
    cyc();
    check("rmid_c1_rd",  {31'd0, bus.mem_read}, 32'd1);
    cyc();
    check("rmid_c2_rd",  {31'd0, bus.mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmid_c2_bw",  {31'd0, bus.if_busywait}, 32'd0);
    cyc();
    check("rmid_c3_rd",   {31'd0, bus.mem_read}, 32'd0);
    check("rmid_c3_addr", bus.mem_addr, 32'd0);
    check("rmid_c3_data", bus.if_readdata, 32'd0);
    rst_n       = 1'b1;
    bus.if_read = 1'b0;
    cyc();
    check("rmid_c4_rd",  {31'd0, bus.mem_read}, 32'd0);
    check("rmid_c4_bw",  {31'd0, bus.if_busywait}, 32'd0);

    // ---- Fresh zero-wait fetch after the abandoned one ----
    mem_wait    = 0;
    mem_word    = 32'hCAFE_F00D;
    bus.if_read = 1'b1;
    bus.if_addr = 32'h0000_0087;
    #1;
    run_until_free(1'b0, bw_n, rd_n, wr_n, a);
    check("f0w_bw_cycles", bw_n, 32'd2);
    check("f0w_rd_cycles", rd_n, 32'd1);
    check("f0w_addr",      a, 32'h0000_0084);
    check("f0w_data",      bus.if_readdata, 32'hCAFE_F00D);
    bus.if_read = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
